// File: rtl/fft_input_loader.sv
// -----------------------------------------------------------------------------
// fft_input_loader
//
// Front-end loader for the in-place radix-2 FFT core. Complex samples arrive
// over a valid/ready handshake, are sign-extended from IN_WIDTH to bit_width,
// and are written into the shared working memory at the bit-reversed address
// of their index within the frame. After the N-th sample is written, a single
// start pulse is issued to the FFT controller. The loader then refuses input
// until the controller's done level rises.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   input sample valid
//   in_re       in   signed real part        [IN_WIDTH-1:0]
//   in_im       in   signed imaginary part   [IN_WIDTH-1:0]
//   in_ready    out  loader accepts a sample this cycle (registered)
//   flush       in   synchronous abort of a partially loaded frame
//   fft_done    in   completion level from the FFT controller
//   mem_we      out  working-memory write enable
//   mem_addr    out  bit-reversed write address; MSB always 0  [SIZE:0]
//   mem_re      out  write data, real part       [bit_width-1:0]
//   mem_im      out  write data, imaginary part  [bit_width-1:0]
//   start_fft   out  one-cycle start pulse to the controller
//   busy        out  high from first accepted sample until FFT completion
//   sample_cnt  out  samples accepted in the current frame (0..N)  [SIZE:0]
// -----------------------------------------------------------------------------
module fft_input_loader #(
  parameter int bit_width = 29,
  parameter int IN_WIDTH  = 16,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_re,
  input  logic signed [IN_WIDTH-1:0]  in_im,
  output logic                        in_ready,
  input  logic                        flush,
  input  logic                        fft_done,
  output logic                        mem_we,
  output logic        [SIZE:0]        mem_addr,
  output logic signed [bit_width-1:0] mem_re,
  output logic signed [bit_width-1:0] mem_im,
  output logic                        start_fft,
  output logic                        busy,
  output logic        [SIZE:0]        sample_cnt
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [SIZE:0] LAST_IDX = (SIZE+1)'(N - 1);
  localparam logic [SIZE:0] CNT_ONE  = (SIZE+1)'(1);

  // Mirror the low SIZE bits of the sample index.
  function automatic logic [SIZE-1:0] bitrev(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++) begin
      r[i] = v[SIZE-1-i];
    end
    return r;
  endfunction

  state_e                      state_q;
  logic                        in_ready_q;
  logic                        mem_we_q;
  logic        [SIZE:0]        mem_addr_q;
  logic signed [bit_width-1:0] mem_re_q;
  logic signed [bit_width-1:0] mem_im_q;
  logic                        start_fft_q;
  logic                        busy_q;
  logic        [SIZE:0]        sample_cnt_q;
  logic                        done_prev_q;

  logic transfer;
  logic last_xfer;
  logic done_rise;

  // A flush in LOAD takes priority over a simultaneous transfer, so the
  // sample presented with flush is dropped.
  assign transfer  = (state_q == ST_LOAD) && in_ready_q && in_valid && !flush;
  assign last_xfer = transfer && (sample_cnt_q == LAST_IDX);

  // Completion is an edge of the done level, not the level itself: a level
  // left high from the previous frame must not end the current wait.
  assign done_rise = fft_done && !done_prev_q;

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values of the others, regardless of the
  // statement order inside this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_re_q     <= '0;
      mem_im_q     <= '0;
      start_fft_q  <= 1'b0;
      busy_q       <= 1'b0;
      sample_cnt_q <= '0;
      done_prev_q  <= 1'b0;
    end else begin
      done_prev_q <= fft_done;
      // Strobes default low; address and data hold their last value.
      mem_we_q    <= 1'b0;
      start_fft_q <= 1'b0;

      case (state_q)
        ST_LOAD: begin
          // in_ready is 0 for the first cycle after reset release, then 1.
          in_ready_q <= 1'b1;
          if (flush) begin
            sample_cnt_q <= '0;
            busy_q       <= 1'b0;
          end else if (transfer) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= {1'b0, bitrev(sample_cnt_q[SIZE-1:0])};
            // Signed size cast: sign extension, no shift, no saturation.
            mem_re_q     <= bit_width'(in_re);
            mem_im_q     <= bit_width'(in_im);
            sample_cnt_q <= sample_cnt_q + CNT_ONE;
            busy_q       <= 1'b1;
            if (last_xfer) begin
              state_q    <= ST_START;
              in_ready_q <= 1'b0;
            end
          end
        end

        // The last write is on the memory port during this cycle; the start
        // pulse is registered here so it appears in the following cycle,
        // after the whole frame is in memory.
        ST_START: begin
          in_ready_q  <= 1'b0;
          start_fft_q <= 1'b1;
          state_q     <= ST_WAIT;
        end

        // Flush is ignored here: a running FFT is never aborted.
        ST_WAIT: begin
          in_ready_q <= 1'b0;
          if (done_rise) begin
            state_q      <= ST_LOAD;
            in_ready_q   <= 1'b1;
            sample_cnt_q <= '0;
            busy_q       <= 1'b0;
          end
        end

        default: begin
          state_q    <= ST_LOAD;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_re     = mem_re_q;
  assign mem_im     = mem_im_q;
  assign start_fft  = start_fft_q;
  assign busy       = busy_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// -----------------------------------------------------------------------------
// tb_fft_input_loader
//
// Directed bench for fft_input_loader (N=16, IN_WIDTH=16, bit_width=29).
// Inputs are driven 1 ns after the rising edge; outputs are sampled at the
// same point, i.e. well away from the active edge.
// -----------------------------------------------------------------------------
module tb_fft_input_loader;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic        [15:0] in_re;
  logic        [15:0] in_im;
  logic               in_ready;
  logic               flush;
  logic               fft_done;
  logic               mem_we;
  logic        [4:0]  mem_addr;
  logic        [28:0] mem_re;
  logic        [28:0] mem_im;
  logic               start_fft;
  logic               busy;
  logic        [4:0]  sample_cnt;

  int total = 0;
  int bad   = 0;

  // Hand-computed 4-bit bit-reversal of sample indices 0..15.
  int exp_addr[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  fft_input_loader #(
    .bit_width(29),
    .IN_WIDTH (16),
    .N        (16),
    .SIZE     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_ready  (in_ready),
    .flush     (flush),
    .fft_done  (fft_done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_im    (mem_im),
    .start_fft (start_fft),
    .busy      (busy),
    .sample_cnt(sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (bad=%0d)", bad);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample, clock it in, and check the resulting write.
  task automatic push(input int idx, input int re, input int im);
    logic [28:0] er;
    logic [28:0] ei;
    er       = 29'(re);
    ei       = 29'(im);
    in_valid = 1'b1;
    in_re    = 16'(re);
    in_im    = 16'(im);
    tick();
    check($sformatf("we[%0d]", idx),   64'(mem_we),     64'd1);
    check($sformatf("addr[%0d]", idx), 64'(mem_addr),   64'(exp_addr[idx]));
    check($sformatf("re[%0d]", idx),   64'(mem_re),     64'(er));
    check($sformatf("im[%0d]", idx),   64'(mem_im),     64'(ei));
    check($sformatf("cnt[%0d]", idx),  64'(sample_cnt), 64'(idx + 1));
  endtask

  initial begin
    int nwr;
    int nstart;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    flush    = 1'b0;
    fft_done = 1'b0;

    // ---------------- reset state ----------------
    #1;
    check("rst_ctrl", 64'({in_ready, mem_we, start_fft, busy}), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_data", 64'({mem_re, mem_im}), 64'd0);
    check("rst_cnt",  64'(sample_cnt), 64'd0);
    @(posedge clk);
    tick();
    rst_n = 1'b1;
    check("rdy_first_cycle", 64'(in_ready), 64'd0);
    tick();
    check("rdy_after", 64'(in_ready), 64'd1);

    // ---------------- full frame ----------------
    for (int k = 0; k < 16; k++) push(k, k, -k);
    in_valid = 1'b0;
    check("ff_rdy_drop", 64'(in_ready), 64'd0);
    check("ff_start_early", 64'(start_fft), 64'd0);
    tick();
    check("ff_start", 64'(start_fft), 64'd1);
    check("ff_we_off", 64'(mem_we), 64'd0);
    tick();
    check("ff_start_one", 64'(start_fft), 64'd0);
    check("ff_wait_rdy", 64'(in_ready), 64'd0);
    check("ff_wait_busy", 64'(busy), 64'd1);
    check("ff_wait_cnt", 64'(sample_cnt), 64'd16);
    fft_done = 1'b1;
    tick();
    check("ff_done_rdy", 64'(in_ready), 64'd1);
    check("ff_done_cnt", 64'(sample_cnt), 64'd0);
    check("ff_done_busy", 64'(busy), 64'd0);

    // ------- sign extension + stale done (fft_done still high) -------
    push(0, -32768, 32767);
    check("sx_re", 64'(mem_re), 64'h1FFF8000);
    check("sx_im", 64'(mem_im), 64'h00007FFF);
    for (int k = 1; k < 16; k++) push(k, k, k);
    in_valid = 1'b0;
    repeat (4) tick();
    check("stale_rdy", 64'(in_ready), 64'd0);
    check("stale_busy", 64'(busy), 64'd1);
    fft_done = 1'b0;
    tick();
    check("stale_low_rdy", 64'(in_ready), 64'd0);
    fft_done = 1'b1;
    tick();
    check("stale_rise_rdy", 64'(in_ready), 64'd1);
    check("stale_rise_cnt", 64'(sample_cnt), 64'd0);
    check("stale_rise_busy", 64'(busy), 64'd0);

    // ---------------- gapped valid ----------------
    nwr    = 0;
    nstart = 0;
    for (int i = 0; i < 32; i++) begin
      in_valid = (i % 2 == 0);
      in_re    = 16'(i);
      in_im    = 16'(i);
      tick();
      if (mem_we) begin
        check($sformatf("gap_addr[%0d]", nwr), 64'(mem_addr),
              64'(exp_addr[nwr]));
        nwr++;
      end
      check($sformatf("gap_cnt[%0d]", i), 64'(sample_cnt), 64'(nwr));
      if (start_fft) begin
        nstart++;
        check("gap_start_cycle", 64'(i), 64'd31);
      end
    end
    in_valid = 1'b0;
    check("gap_writes", 64'(nwr), 64'd16);
    check("gap_starts", 64'(nstart), 64'd1);
    fft_done = 1'b0;
    tick();
    fft_done = 1'b1;
    tick();
    check("gap_done_rdy", 64'(in_ready), 64'd1);
    fft_done = 1'b0;

    // ---------------- flush ----------------
    for (int k = 0; k < 5; k++) push(k, 100 + k, -100 - k);
    in_valid = 1'b1;
    flush    = 1'b1;
    in_re    = 16'd77;
    in_im    = 16'd77;
    tick();
    check("fl_we", 64'(mem_we), 64'd0);
    check("fl_cnt", 64'(sample_cnt), 64'd0);
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_addr_hold", 64'(mem_addr), 64'd2);
    flush = 1'b0;
    push(0, 55, -55);

    // ---------------- reset mid-frame ----------------
    for (int k = 1; k < 7; k++) push(k, k, k);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mr_ctrl", 64'({in_ready, mem_we, start_fft, busy}), 64'd0);
    check("mr_addr", 64'(mem_addr), 64'd0);
    check("mr_data", 64'({mem_re, mem_im}), 64'd0);
    check("mr_cnt",  64'(sample_cnt), 64'd0);
    @(posedge clk);
    tick();
    rst_n = 1'b1;
    check("mr_rdy_first", 64'(in_ready), 64'd0);
    tick();
    check("mr_rdy", 64'(in_ready), 64'd1);
    nstart = 0;
    for (int k = 0; k < 16; k++) begin
      push(k, 2 * k, -2 * k);
      if (start_fft) nstart++;
    end
    in_valid = 1'b0;
    repeat (4) begin
      tick();
      if (start_fft) nstart++;
    end
    check("mr_starts", 64'(nstart), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Front-end loader for the in-place radix-2 FFT core. It accepts a stream of complex samples over a valid/ready handshake, sign-extends each sample to the core's internal width, and writes it into the shared working memory at its bit-reversed address. Once a full frame of N samples is stored, it pulses the FFT controller's start input, then holds off new input until the controller reports completion. It sits directly upstream of the FFT controller and shares the working memory write port with it.

## Interface

Parameters:
- bit_width, 29, internal signed sample width written to memory.
- IN_WIDTH, 16, signed input sample width; IN_WIDTH <= bit_width.
- N, 16, frame length in points; N = 2^SIZE.
- SIZE, 4, log2(N); memory address is SIZE+1 bits.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input sample valid.
- in_re  in  IN_WIDTH  signed real part.
- in_im  in  IN_WIDTH  signed imaginary part.
- in_ready  out  1  loader can accept a sample this cycle.
- flush  in  1  synchronous frame abort; discards the partially loaded frame.
- fft_done  in  1  completion level from the FFT controller (its done_o).
- mem_we  out  1  memory write enable.
- mem_addr  out  SIZE+1  write address, bit-reversed sample index; MSB always 0.
- mem_re  out  bit_width  write data, real part.
- mem_im  out  bit_width  write data, imaginary part.
- start_fft  out  1  one-cycle start pulse to the controller (flag_start_FFT).
- busy  out  1  high from the first accepted sample until the FFT completes.
- sample_cnt  out  SIZE+1  number of samples accepted in the current frame (0..N).

## Operation

- States: LOAD, START, WAIT.
- Reset: state LOAD; in_ready 0 in the first cycle after reset release, then 1. At reset, mem_we=0, mem_addr=0, mem_re=0, mem_im=0, start_fft=0, busy=0, sample_cnt=0, and the fft_done history register=0.
- LOAD: in_ready=1. A transfer occurs when in_valid && in_ready at a clock edge. On a transfer:
  - mem_addr <= {1'b0, bitrev_SIZE(sample_cnt)}.
  - mem_re/mem_im <= the sample sign-extended from IN_WIDTH to bit_width. No shift, no saturation.
  - mem_we <= 1 and sample_cnt <= sample_cnt+1.
  - busy <= 1.
- When a transfer occurs with sample_cnt == N-1, the next state is START, in_ready drops in the following cycle, and sample_cnt reads N.
- START: lasts one cycle. start_fft=1, mem_we=0, in_ready=0. The next state is WAIT.
- WAIT: in_ready=0 and mem_we=0. The block waits for a rising edge of fft_done, detected against a registered previous value. On that edge: state -> LOAD, sample_cnt <= 0, busy <= 0.
- A level that is already high on entry to WAIT (left over from the previous frame) does not count as completion.
- flush in LOAD: sample_cnt <= 0, busy <= 0, and no write that cycle, even if in_valid is high. Memory contents are left stale; the next frame overwrites them.
- flush in START or WAIT: ignored. A running FFT is not aborted.
- Cycles without a transfer: mem_we=0; mem_addr and mem data hold their last values.

## Timing

- Write latency: a sample accepted at edge t appears on mem_we/mem_addr/mem_re/mem_im during the cycle after edge t.
- Throughput: one sample per clock when in_valid is held high; N cycles per frame.
- start_fft is high exactly one cycle, in the cycle immediately after the cycle in which the last mem_we was asserted. The controller therefore sees the full frame in memory before it starts reading.
- in_ready is a registered output; it depends on state only, never combinationally on in_valid.
- Frame-to-frame gap: from the first cycle fft_done is high after being low, in_ready returns to 1 on the next cycle.
- Simultaneous flush and transfer in LOAD: flush wins, and the sample is dropped.
- Reset asserted mid-frame or mid-WAIT: all outputs return to their reset values asynchronously. After release, loading restarts from index 0.

## Test plan

- Full frame, N=16: drive samples k=0..15 with in_re=k and in_im=-k, in_valid held high. Expect 16 consecutive mem_we cycles with addresses 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. Expect start_fft high for one cycle, immediately after the last write. Expect in_ready=0 from then on.
- Sign extension: in_re=16'h8000 and in_im=16'h7FFF. Expect mem_re = -32768 and mem_im = 32767 in 29 bits (29'h1FFF8000 and 29'h0000_7FFF).
- Gapped valid: toggle in_valid every other cycle. Expect exactly 16 writes over 32 cycles, sample_cnt stepping only on transfers, and start_fft after the 16th write.
- Stale done: hold fft_done=1 when WAIT is entered. Expect the block to stay in WAIT. Then drive fft_done 0 -> 1. Expect in_ready=1 one cycle later, sample_cnt=0, and busy=0.
- Flush: load 5 samples, then assert flush together with in_valid. Expect no write that cycle and sample_cnt=0. The next sample is written to address 0.
- Reset mid-frame: assert rst_n=0 after 7 samples. Expect all outputs to clear immediately. After release, a new 16-sample frame loads normally with exactly one start_fft pulse.
